// File: rtl/matrix_issue_q.sv
// rtl/matrix_issue_q.sv - in-order matrix-multiply issue queue with RAW scoreboard; define MATRIX_ISSUE_PERF_EN for issue/stall counters
module matrix_issue_q #(
    parameter int QDEPTH   = 4,
    parameter int IDXW     = 8,
    parameter int PIPE_STG = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_vld,
    input  logic [IDXW-1:0]           in_rd,
    input  logic [IDXW-1:0]           in_rs1,
    input  logic [IDXW-1:0]           in_rs2,
    output logic                      in_rdy,
    input  logic                      bru_vld,
    input  logic                      bru_flush,
    output logic                      iss_vld,
    output logic [IDXW-1:0]           iss_rd,
    output logic [IDXW-1:0]           iss_rs1,
    output logic [IDXW-1:0]           iss_rs2,
    output logic                      busy,
`ifdef MATRIX_ISSUE_PERF_EN
    output logic [31:0]               issue_cnt,
    output logic [31:0]               stall_cnt,
`endif
    output logic [$clog2(QDEPTH):0]   q_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] L_DEPTH = (PW+1)'(QDEPTH);

    logic [IDXW-1:0] r_mem_rd  [QDEPTH];
    logic [IDXW-1:0] r_mem_rs1 [QDEPTH];
    logic [IDXW-1:0] r_mem_rs2 [QDEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [PW:0]     r_cnt;

    // Scoreboard: index 0 is the stage just after issue (preadder).
    logic [PIPE_STG-1:0] r_sb_vld;
    logic [IDXW-1:0]     r_sb_rd [PIPE_STG];

    logic w_flush;
    logic w_nonempty;
    logic w_hazard;
    logic w_iss;
    logic w_push;

    assign w_flush    = bru_vld & bru_flush;
    assign w_nonempty = (r_cnt != '0);
    assign in_rdy     = (r_cnt < L_DEPTH);
    assign w_push     = in_vld & in_rdy & ~w_flush;
    assign w_iss      = ~rst & ~w_flush & w_nonempty & ~w_hazard;

    // RAW check of the head sources against every in-flight destination
    always_comb begin
        w_hazard = 1'b0;
        for (int k = 0; k < PIPE_STG; k++) begin
            if (r_sb_vld[k] && ((r_sb_rd[k] == r_mem_rs1[r_rptr]) ||
                                (r_sb_rd[k] == r_mem_rs2[r_rptr]))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign iss_vld = w_iss;
    assign iss_rd  = w_iss ? r_mem_rd[r_rptr]  : '0;
    assign iss_rs1 = w_iss ? r_mem_rs1[r_rptr] : '0;
    assign iss_rs2 = w_iss ? r_mem_rs2[r_rptr] : '0;
    assign busy    = ~rst & (w_nonempty | (|r_sb_vld));
    assign q_cnt   = r_cnt;

    // Queue pointers and occupancy; flush empties, reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else if (w_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_iss)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_iss})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Queue payload storage, no reset needed
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem_rd[r_wptr]  <= in_rd;
            r_mem_rs1[r_wptr] <= in_rs1;
            r_mem_rs2[r_wptr] <= in_rs2;
        end
    end

    // Scoreboard valid shift; a flushed cycle never issues so stage 0 loads 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb_vld <= '0;
        end else begin
            for (int k = PIPE_STG-1; k > 0; k--) r_sb_vld[k] <= r_sb_vld[k-1];
            r_sb_vld[0] <= w_iss;
        end
    end

    // Scoreboard destination shift, qualified by r_sb_vld
    always_ff @(posedge clk) begin
        for (int k = PIPE_STG-1; k > 0; k--) r_sb_rd[k] <= r_sb_rd[k-1];
        r_sb_rd[0] <= iss_rd;
    end

`ifdef MATRIX_ISSUE_PERF_EN
    // Saturating issue and hazard-stall counters, untouched by flush
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (w_iss && (issue_cnt != '1)) issue_cnt <= issue_cnt + 1'b1;
            if (w_nonempty && w_hazard && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/matrix_issue_q.md
MATRIX_ISSUE_Q -- requirements
Module: matrix_issue_q

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, queue entries (power of two, >=2).
REQ-002 SHALL have parameter IDXW, default 8, matrix-memory index width (256-deep matrix memory).
REQ-003 SHALL have parameter PIPE_STG, default 3, accelerator stages from issue to matrix-memory write (preadder, multiplier, postadder).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_vld  input  1  IDU offers a decoded matrix-multiply instruction.
REQ-007 in_rd / in_rs1 / in_rs2  input  IDXW each  destination and source matrix indices.
REQ-008 in_rdy  output  1  queue accepts; transfer occurs when in_vld & in_rdy.
REQ-009 bru_vld / bru_flush  input  1 each  branch resolution; flush = bru_vld & bru_flush.
REQ-010 iss_vld  output  1  one instruction issued this cycle to the accelerator (its mul_vld).
REQ-011 iss_rd / iss_rs1 / iss_rs2  output  IDXW each  indices of the issued instruction, driven directly onto matrix-memory read ports.
REQ-012 busy  output  1  queue non-empty or any scoreboard stage valid.
REQ-013 q_cnt  output  log2(QDEPTH)+1  current occupancy.

Function
REQ-014 SHALL buffer accepted instructions in an in-order circular FIFO; write/read pointers wrap modulo QDEPTH.
REQ-015 in_rdy SHALL be 1 iff q_cnt < QDEPTH, computed from registered state only; no push-through when full, even with a same-cycle pop.
REQ-016 No bypass: an instruction accepted in cycle t SHALL issue no earlier than t+1.
REQ-017 SHALL keep a PIPE_STG-entry scoreboard shift register of {vld, rd}: stage 1 loads {iss_vld, iss_rd} each cycle; stage k loads stage k-1.
REQ-018 Head SHALL stall if its rs1 or rs2 equals the rd of any valid scoreboard stage (RAW; matrix memory has no write-to-read bypass).
REQ-019 Consequence: dependent instruction issued at t, producer issued at t0, SHALL satisfy t >= t0+PIPE_STG+1; independent instructions issue back-to-back, one per cycle.
REQ-020 iss_vld SHALL be 1 iff queue non-empty, no hazard, and no flush; iss_* indices SHALL be 0 when iss_vld=0.
REQ-021 Issue SHALL pop the head in the same cycle; push and pop in one cycle SHALL leave q_cnt unchanged.
REQ-022 On flush: queue SHALL be emptied (pointers and count to 0), iss_vld SHALL be 0 that cycle, any same-cycle push SHALL be discarded, scoreboard stage-1 vld SHALL clear (accelerator preadder kills that instruction); stages 2..PIPE_STG SHALL advance normally.
REQ-023 WAW/WAR need no checks (in-order, single pipe).

Reset
REQ-024 With rst=1 at a clock edge: pointers, q_cnt, all scoreboard vld SHALL be 0; FIFO data SHALL need no reset.
REQ-025 During and after reset: iss_vld=0, iss_*=0, busy=0, in_rdy=1 from the first cycle after reset deasserts; rst SHALL override flush and push.
REQ-026 Reset mid-operation SHALL discard all queued and tracked instructions; no issue in the reset cycle.

Configuration
REQ-027 Macro MATRIX_ISSUE_PERF_EN defined: SHALL add outputs issue_cnt and stall_cnt (32 bits each), counting cycles with iss_vld=1 and cycles with non-empty queue blocked by a hazard; both saturate at all-ones, reset to 0, flush does not clear them.
REQ-028 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-029 Push A(rd=5,rs1=1,rs2=2) at t=0, then B(rd=6,rs1=5,rs2=3) -> A issues t=1; B issues t=5, not before.
REQ-030 Push 4 independent instructions back-to-back -> issue on 4 consecutive cycles; q_cnt peaks at 1; busy falls 3 cycles after last issue.
REQ-031 Stall head with a hazard, push until q_cnt=4 -> in_rdy=0; 5th in_vld not accepted; drain order is FIFO with wrap-around correct.
REQ-032 Queue holding 3 entries, bru_vld=1 & bru_flush=1 with simultaneous push -> iss_vld=0, q_cnt=0 next cycle, pushed entry dropped; bru_flush=1 with bru_vld=0 -> no effect.
REQ-033 Assert rst for one cycle with queue 2 and scoreboard full -> next cycle q_cnt=0, busy=0, in_rdy=1, iss_vld=0; a dependent instruction pushed then issues at t+1.
REQ-034 With MATRIX_ISSUE_PERF_EN, REQ-029 stimulus -> issue_cnt=2, stall_cnt=3.
